// File: rtl/ebus_pkg.sv
// rtl/ebus_pkg.sv - EBUS widths, function codes and responder state encoding
package ebus_pkg;

    localparam int EBUS_DS_W   = 7;
    localparam int EBUS_DATA_W = 36;

    typedef logic [0:EBUS_DS_W-1]   ebus_ds_t;
    typedef logic [0:EBUS_DATA_W-1] ebus_data_t;
    typedef logic [0:2]             ebus_func_t;

    localparam ebus_func_t EBUS_FUNC_CONO  = 3'd0;
    localparam ebus_func_t EBUS_FUNC_CONI  = 3'd1;
    localparam ebus_func_t EBUS_FUNC_DATAO = 3'd2;
    localparam ebus_func_t EBUS_FUNC_DATAI = 3'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_XFER    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/ebus_parity.sv
// rtl/ebus_parity.sv - 36-bit odd parity generator (data -> bit making total ones odd)
module ebus_parity
    import ebus_pkg::*;
(
    input  logic [0:EBUS_DATA_W-1] data,    // word to protect
    output logic                   odd_par  // 1 when data has an even number of ones
);

    assign odd_par = ~(^data);

endmodule

// File: rtl/ebus_dev_responder.sv
// rtl/ebus_dev_responder.sv - EBUS device-side responder; EBUS_PARITY_EN adds parity check/generation
module ebus_dev_responder
    import ebus_pkg::*;
#(
    parameter logic [0:EBUS_DS_W-1] DEV_ADDR = 7'o070, // controller select answered
    parameter int                   RD_WAIT  = 2       // accept-to-capture delay for reads (0..15)
) (
    input  logic                   eboxClk,        // all state on posedge
    input  logic                   eboxReset,      // async, active high
    input  logic [0:EBUS_DS_W-1]   EBUS_DS,        // controller select
    input  logic [0:2]             EBUS_func,      // CONO/CONI/DATAO/DATAI, 4-7 ignored
    input  logic                   EBUS_demand,    // held until devTransfer seen
    input  logic [0:EBUS_DATA_W-1] EBUS_dataIn,    // write data from EDP
`ifdef EBUS_PARITY_EN
    input  logic                   EBUS_parityIn,  // odd parity bit for EBUS_dataIn
`endif
    input  logic [0:EBUS_DATA_W-1] devConiData,    // status word returned on CONI
    input  logic [0:EBUS_DATA_W-1] devDataiData,   // data word returned on DATAI
    output logic                   devTransfer,    // transfer acknowledge
    output logic                   devDrivingEBUS, // devEBUS is being driven
    output logic [0:EBUS_DATA_W-1] devEBUS,        // read data
    output logic [0:EBUS_DATA_W-1] devWriteData,   // last CONO/DATAO word
    output logic                   devConoStrobe,  // one-cycle CONO pulse
    output logic                   devDataoStrobe, // one-cycle DATAO pulse
`ifdef EBUS_PARITY_EN
    output logic                   devEBUSparity,  // odd parity of devEBUS
    output logic                   devParityErr,   // one-cycle pulse on bad write parity
`endif
    output logic                   devBusy         // not idle
);

    logic [1:0] state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       demand_prev_q;
    logic       is_datai_q, is_datai_d;
    logic       transfer_q, transfer_d;
    logic       driving_q, driving_d;
    ebus_data_t dev_ebus_q, dev_ebus_d;
    ebus_data_t wdata_q, wdata_d;
    logic       cono_q, cono_d;
    logic       datao_q, datao_d;

    logic       accept;
    logic       is_write;
    logic       is_read;
    logic       parity_ok;
    logic [3:0] wait_dec;

`ifdef EBUS_PARITY_EN
    logic in_par;
    logic ebus_par_d, ebus_par_q;
    logic perr_q, perr_d;

    ebus_parity u_par_in (
        .data    (EBUS_dataIn),
        .odd_par (in_par)
    );

    // Parity is computed on the next devEBUS value so it registers alongside it.
    ebus_parity u_par_out (
        .data    (dev_ebus_d),
        .odd_par (ebus_par_d)
    );

    assign parity_ok = (EBUS_parityIn == in_par);
`else
    assign parity_ok = 1'b1;
`endif

    assign is_write = (EBUS_func == EBUS_FUNC_CONO) || (EBUS_func == EBUS_FUNC_DATAO);
    assign is_read  = (EBUS_func == EBUS_FUNC_CONI) || (EBUS_func == EBUS_FUNC_DATAI);
    // Edge-qualified so a demand still held after a transfer cannot start another one.
    assign accept   = EBUS_demand && !demand_prev_q && (EBUS_DS == DEV_ADDR) && (is_write || is_read);
    assign wait_dec = wait_cnt_q - 4'd1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        is_datai_d = is_datai_q;
        transfer_d = transfer_q;
        driving_d  = driving_q;
        dev_ebus_d = dev_ebus_q;
        wdata_d    = wdata_q;
        cono_d     = 1'b0;
        datao_d    = 1'b0;
`ifdef EBUS_PARITY_EN
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_write) begin
                        wdata_d    = EBUS_dataIn;
                        cono_d     = parity_ok && (EBUS_func == EBUS_FUNC_CONO);
                        datao_d    = parity_ok && (EBUS_func == EBUS_FUNC_DATAO);
`ifdef EBUS_PARITY_EN
                        perr_d     = !parity_ok;
`endif
                        transfer_d = 1'b1;
                        state_d    = ST_XFER;
                    end else begin
                        is_datai_d = (EBUS_func == EBUS_FUNC_DATAI);
                        if (RD_WAIT == 0) begin
                            dev_ebus_d = (EBUS_func == EBUS_FUNC_DATAI) ? devDataiData : devConiData;
                            driving_d  = 1'b1;
                            transfer_d = 1'b1;
                            state_d    = ST_XFER;
                        end else begin
                            wait_cnt_d = 4'(RD_WAIT);
                            state_d    = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!EBUS_demand) begin
                    // EBOX gave up; nothing has been driven yet.
                    state_d = ST_IDLE;
                end else if (wait_dec == 4'd0) begin
                    dev_ebus_d = is_datai_q ? devDataiData : devConiData;
                    driving_d  = 1'b1;
                    transfer_d = 1'b1;
                    wait_cnt_d = 4'd0;
                    state_d    = ST_XFER;
                end else begin
                    wait_cnt_d = wait_dec;
                end
            end
            ST_XFER: begin
                if (!EBUS_demand) begin
                    transfer_d = 1'b0;
                    state_d    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Read data stayed on the bus one cycle past transfer for hold time.
                driving_d  = 1'b0;
                dev_ebus_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge eboxClk or posedge eboxReset) begin
        if (eboxReset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 4'd0;
            demand_prev_q <= 1'b0;
            is_datai_q    <= 1'b0;
            transfer_q    <= 1'b0;
            driving_q     <= 1'b0;
            dev_ebus_q    <= '0;
            wdata_q       <= '0;
            cono_q        <= 1'b0;
            datao_q       <= 1'b0;
`ifdef EBUS_PARITY_EN
            ebus_par_q    <= 1'b0;
            perr_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            demand_prev_q <= EBUS_demand;
            is_datai_q    <= is_datai_d;
            transfer_q    <= transfer_d;
            driving_q     <= driving_d;
            dev_ebus_q    <= dev_ebus_d;
            wdata_q       <= wdata_d;
            cono_q        <= cono_d;
            datao_q       <= datao_d;
`ifdef EBUS_PARITY_EN
            ebus_par_q    <= ebus_par_d;
            perr_q        <= perr_d;
`endif
        end
    end

    assign devTransfer    = transfer_q;
    assign devDrivingEBUS = driving_q;
    assign devEBUS        = dev_ebus_q;
    assign devWriteData   = wdata_q;
    assign devConoStrobe  = cono_q;
    assign devDataoStrobe = datao_q;
    assign devBusy        = (state_q != ST_IDLE);
`ifdef EBUS_PARITY_EN
    assign devEBUSparity  = ebus_par_q;
    assign devParityErr   = perr_q;
`endif

endmodule

// File: tb/tb_ebus_dev_responder.sv
// tb/tb_ebus_dev_responder.sv - directed table-driven bench for ebus_dev_responder
module tb_ebus_dev_responder;
    import ebus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:6]  ds;
    logic [0:2]  func;
    logic        demand;
    logic [0:35] din;
    logic [0:35] coni;
    logic [0:35] datai;
    logic        dev_transfer;
    logic        dev_driving;
    logic [0:35] dev_ebus;
    logic [0:35] dev_wdata;
    logic        dev_cono;
    logic        dev_datao;
    logic        dev_busy;
`ifdef EBUS_PARITY_EN
    logic        par_in;
    logic        dev_ebus_par;
    logic        dev_perr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ebus_dev_responder dut (
        .eboxClk        (clk),
        .eboxReset      (rst),
        .EBUS_DS        (ds),
        .EBUS_func      (func),
        .EBUS_demand    (demand),
        .EBUS_dataIn    (din),
`ifdef EBUS_PARITY_EN
        .EBUS_parityIn  (par_in),
`endif
        .devConiData    (coni),
        .devDataiData   (datai),
        .devTransfer    (dev_transfer),
        .devDrivingEBUS (dev_driving),
        .devEBUS        (dev_ebus),
        .devWriteData   (dev_wdata),
        .devConoStrobe  (dev_cono),
        .devDataoStrobe (dev_datao),
`ifdef EBUS_PARITY_EN
        .devEBUSparity  (dev_ebus_par),
        .devParityErr   (dev_perr),
`endif
        .devBusy        (dev_busy)
    );

    typedef struct {
        string       name;
        logic [0:6]  ds;
        logic [0:2]  func;
        logic [0:35] wdata;
        logic [0:35] coni;
        logic [0:35] datai;
        int          exp_lat;   // cycles from demand to transfer, 0 = never
        bit          exp_read;
        int          exp_cono;
        int          exp_datao;
        logic [0:35] exp_rd;
        logic [0:35] exp_wd;
    } vec_t;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input vec_t v);
        int lat;
        int n_cono;
        int n_datao;
        bit got;
        lat = 0; n_cono = 0; n_datao = 0; got = 0;
        ds = v.ds; func = v.func; din = v.wdata; coni = v.coni; datai = v.datai;
`ifdef EBUS_PARITY_EN
        par_in = ~(^v.wdata);
`endif
        demand = 1'b1;
        for (int c = 1; c <= 8 && !got; c++) begin
            tick();
            n_cono  += int'(dev_cono);
            n_datao += int'(dev_datao);
            if (dev_transfer) begin
                got = 1;
                lat = c;
            end
        end
        chk({v.name, " latency"}, 36'(lat), 36'(v.exp_lat));
        if (got) begin
            chk({v.name, " busy"}, 36'(dev_busy), 36'd1);
            chk({v.name, " driving"}, 36'(dev_driving), 36'(v.exp_read));
            if (v.exp_read) chk({v.name, " rdata"}, dev_ebus, v.exp_rd);
            tick();
            n_cono  += int'(dev_cono);
            n_datao += int'(dev_datao);
            chk({v.name, " xfer_hold"}, 36'(dev_transfer), 36'd1);
            demand = 1'b0;
            tick();
            n_cono  += int'(dev_cono);
            n_datao += int'(dev_datao);
            chk({v.name, " release_xfer"}, 36'(dev_transfer), 36'd0);
            chk({v.name, " release_drive"}, 36'(dev_driving), 36'(v.exp_read));
            if (v.exp_read) chk({v.name, " release_data"}, dev_ebus, v.exp_rd);
            tick();
            chk({v.name, " idle_busy"}, 36'(dev_busy), 36'd0);
            chk({v.name, " idle_drive"}, 36'(dev_driving), 36'd0);
            chk({v.name, " idle_ebus"}, dev_ebus, 36'd0);
        end else begin
            chk({v.name, " ignored_busy"}, 36'(dev_busy), 36'd0);
            demand = 1'b0;
            tick();
        end
        chk({v.name, " cono_count"}, 36'(n_cono), 36'(v.exp_cono));
        chk({v.name, " datao_count"}, 36'(n_datao), 36'(v.exp_datao));
        chk({v.name, " wdata"}, dev_wdata, v.exp_wd);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"cono",        7'o070, 3'd0, 36'h123456789, 36'h0,         36'h0,         1, 0, 1, 0, 36'h0,         36'h123456789};
        vecs[1] = '{"datai",       7'o070, 3'd3, 36'h0,         36'h111111111, 36'h987654321, 3, 1, 0, 0, 36'h987654321, 36'h123456789};
        vecs[2] = '{"ds_mismatch", 7'o071, 3'd0, 36'hABCDEF012, 36'h0,         36'h0,         0, 0, 0, 0, 36'h0,         36'h123456789};
        vecs[3] = '{"func5",       7'o070, 3'd5, 36'hABCDEF012, 36'h0,         36'h0,         0, 0, 0, 0, 36'h0,         36'h123456789};
        vecs[4] = '{"coni",        7'o070, 3'd1, 36'h0,         36'h0F00DCAFE, 36'h222222222, 3, 1, 0, 0, 36'h0F00DCAFE, 36'h123456789};
        vecs[5] = '{"datao_ones",  7'o070, 3'd2, 36'hFFFFFFFFF, 36'h0,         36'h0,         1, 0, 0, 1, 36'h0,         36'hFFFFFFFFF};
        vecs[6] = '{"func7",       7'o070, 3'd7, 36'h555555555, 36'h0,         36'h0,         0, 0, 0, 0, 36'h0,         36'hFFFFFFFFF};
        vecs[7] = '{"datao_ends",  7'o070, 3'd2, 36'h800000001, 36'h0,         36'h0,         1, 0, 0, 1, 36'h0,         36'h800000001};

        ds = 7'o0; func = 3'd0; demand = 1'b0; din = '0; coni = '0; datai = '0;
`ifdef EBUS_PARITY_EN
        par_in = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        chk("reset transfer", 36'(dev_transfer), 36'd0);
        chk("reset driving", 36'(dev_driving), 36'd0);
        chk("reset ebus", dev_ebus, 36'd0);
        chk("reset wdata", dev_wdata, 36'd0);
        chk("reset strobes", 36'({dev_cono, dev_datao}), 36'd0);
        chk("reset busy", 36'(dev_busy), 36'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Read aborted while waiting for data
        ds = 7'o070; func = 3'd1; coni = 36'h345345345; demand = 1'b1;
        tick();
        chk("abort wait_busy", 36'(dev_busy), 36'd1);
        chk("abort wait_xfer", 36'(dev_transfer), 36'd0);
        demand = 1'b0;
        tick();
        chk("abort idle_busy", 36'(dev_busy), 36'd0);
        chk("abort drive", 36'(dev_driving), 36'd0);
        chk("abort ebus", dev_ebus, 36'd0);
        tick();
        chk("abort no_xfer", 36'(dev_transfer), 36'd0);

        // Demand already high when the select starts matching: no rising edge, no accept
        ds = 7'o071; func = 3'd0; din = 36'h0DEADBEEF; demand = 1'b1;
        tick();
        tick();
        ds = 7'o070;
        tick();
        tick();
        chk("level_held busy", 36'(dev_busy), 36'd0);
        chk("level_held xfer", 36'(dev_transfer), 36'd0);
        chk("level_held wdata", dev_wdata, 36'h800000001);
        demand = 1'b0;
        tick();

        // Reset during XFER clears everything without waiting for a clock
        ds = 7'o070; func = 3'd2; din = 36'h0AAAA5555;
`ifdef EBUS_PARITY_EN
        par_in = ~(^din);
`endif
        demand = 1'b1;
        tick();
        chk("rst_xfer pre_strobe", 36'(dev_datao), 36'd1);
        chk("rst_xfer pre_xfer", 36'(dev_transfer), 36'd1);
        rst = 1'b1;
        #1;
        chk("rst_xfer xfer", 36'(dev_transfer), 36'd0);
        chk("rst_xfer strobe", 36'(dev_datao), 36'd0);
        chk("rst_xfer busy", 36'(dev_busy), 36'd0);
        chk("rst_xfer wdata", dev_wdata, 36'd0);
        demand = 1'b0;
        tick();
        rst = 1'b0;
        tick();

`ifdef EBUS_PARITY_EN
        // Zero word with parity bit 0 has an even total: error, no strobe
        ds = 7'o070; func = 3'd2; din = 36'h0; par_in = 1'b0; demand = 1'b1;
        tick();
        chk("par_bad perr", 36'(dev_perr), 36'd1);
        chk("par_bad strobe", 36'(dev_datao), 36'd0);
        chk("par_bad xfer", 36'(dev_transfer), 36'd1);
        tick();
        chk("par_bad perr_pulse", 36'(dev_perr), 36'd0);
        demand = 1'b0;
        tick();
        tick();
        chk("par_bad idle", 36'(dev_busy), 36'd0);
        par_in = 1'b1; demand = 1'b1;
        tick();
        chk("par_ok perr", 36'(dev_perr), 36'd0);
        chk("par_ok strobe", 36'(dev_datao), 36'd1);
        chk("par_ok xfer", 36'(dev_transfer), 36'd1);
        demand = 1'b0;
        tick();
        tick();
        // Read of a single-one word: odd parity bit must be 0
        func = 3'd3; datai = 36'h000000001; demand = 1'b1;
        tick();
        tick();
        tick();
        chk("par_rd xfer", 36'(dev_transfer), 36'd1);
        chk("par_rd ebus_par", 36'(dev_ebus_par), 36'd0);
        demand = 1'b0;
        tick();
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
